// File: rtl/cacheline_adapter.sv
// cacheline_adapter: bridges a 256-bit cache line port to a 4-beat 64-bit memory burst interface.
// Optional feature macro CACHELINE_ADAPTER_BYPASS_EN: completes a fill combinationally on the 4th read beat.
module cacheline_adapter #(
   parameter int S_BEATS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [64*S_BEATS-1:0]   line_i,
   output logic [64*S_BEATS-1:0]   line_o,
   input  logic [31:0]             address_i,
   input  logic                    read_i,
   input  logic                    write_i,
   output logic                    resp_o,
   input  logic [63:0]             burst_i,
   output logic [63:0]             burst_o,
   output logic [31:0]             address_o,
   output logic                    read_o,
   output logic                    write_o,
   input  logic                    resp_i
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   state_t                  state;
   logic [1:0]              cnt;
   logic [64*S_BEATS-1:0]   buffer;
   logic [64*S_BEATS-1:0]   line_r;
   logic                    resp_r;
   // Burst sequencing with all memory-side outputs registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         buffer    <= '0;
         line_r    <= '0;
         resp_r    <= 1'b0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         address_o <= '0;
         burst_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write_i || read_i) begin
                  state     <= write_i ? WRITE : READ;
                  write_o   <= write_i;
                  read_o    <= !write_i;
                  address_o <= {address_i[31:5], 5'b0};
                  buffer    <= line_i;
                  burst_o   <= write_i ? line_i[63:0] : '0;
                  cnt       <= '0;
               end
            end
            READ: begin
               if (resp_i) begin
                  line_r[{cnt, 6'b0} +: 64] <= burst_i;
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     read_o    <= 1'b0;
                     address_o <= '0;
`ifdef CACHELINE_ADAPTER_BYPASS_EN
                     state     <= IDLE;
`else
                     state     <= DONE;
                     resp_r    <= 1'b1;
`endif
                  end
               end
            end
            WRITE: begin
               if (resp_i) begin
                  cnt     <= cnt + 2'd1;
                  burst_o <= buffer[{cnt + 2'd1, 6'b0} +: 64];
                  if (cnt == 2'd3) begin
                     state     <= DONE;
                     resp_r    <= 1'b1;
                     write_o   <= 1'b0;
                     address_o <= '0;
                     burst_o   <= '0;
                  end
               end
            end
            DONE: begin
               resp_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
`ifdef CACHELINE_ADAPTER_BYPASS_EN
   logic last_beat;
   // Final read beat is forwarded straight to the cache together with the completion pulse
   always_comb begin
      last_beat = (state == READ) && resp_i && (cnt == 2'd3);
      resp_o    = resp_r | last_beat;
      line_o    = last_beat ? {burst_i, line_r[191:0]} : line_r;
   end
`else
   // Completion and fill line come straight from registers
   always_comb begin
      resp_o = resp_r;
      line_o = line_r;
   end
`endif
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed checks of fills, write-backs, stalls, priority and reset abort.
module tb_cacheline_adapter;
   logic          clk = 1'b0;
   logic          rst;
   logic [255:0]  line_i, line_o;
   logic [31:0]   address_i, address_o;
   logic          read_i, write_i, resp_o, read_o, write_o, resp_i;
   logic [63:0]   burst_i, burst_o;
   int            checks = 0;
   int            failures = 0;
`ifdef CACHELINE_ADAPTER_BYPASS_EN
   localparam int FILL_EXTRA = 0;
`else
   localparam int FILL_EXTRA = 1;
`endif
   localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] LINE_B = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                      64'h5A5A_5A5A_A5A5_A5A5, 64'hC0DE_0001_C0DE_0002};
   localparam logic [255:0] LINE_W = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

   cacheline_adapter dut (
      .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      line_i = '0; address_i = '0; burst_i = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({resp_o, read_o, write_o} !== 3'b000) begin
         failures++;
         $display("FAIL reset_ctrl: resp/read/write=%b expected 000", {resp_o, read_o, write_o});
      end
      checks++;
      if (address_o !== 32'h0 || burst_o !== 64'h0 || line_o !== 256'h0) begin
         failures++;
         $display("FAIL reset_data: address_o=%h burst_o=%h line_o=%h expected all zero", address_o, burst_o, line_o);
      end
   endtask

   // Issues a fill; pat bit i-1 gives resp_i in cycle i; returns at the negedge of the resp_o cycle
   task automatic run_fill(input string name, input logic [31:0] a, input logic [255:0] exp_line,
                           input logic [31:0] pat, input int exp_lat);
      int k, lat;
      @(posedge clk); #1;
      read_i = 1'b1; write_i = 1'b0; address_i = a; resp_i = 1'b0;
      @(posedge clk); #1;
      k = 0; lat = 0;
      for (int i = 1; i <= 32 && lat == 0; i++) begin
         resp_i = pat[i-1] && (k < 4);
         burst_i = resp_i ? exp_line[64*k +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
         if (resp_i) k++;
         address_i = 32'hFFFF_FFFF;
         @(negedge clk);
         if (i == 1) begin
            checks++;
            if (address_o !== {a[31:5], 5'b0}) begin
               failures++;
               $display("FAIL %s_addr: address_o=%h expected %h", name, address_o, {a[31:5], 5'b0});
            end
            checks++;
            if (read_o !== 1'b1 || write_o !== 1'b0) begin
               failures++;
               $display("FAIL %s_req: read_o=%b write_o=%b expected 1 0", name, read_o, write_o);
            end
         end
         if (resp_o === 1'b1) lat = i;
         else begin
            @(posedge clk); #1;
         end
      end
      resp_i = 1'b0;
      checks++;
      if (lat !== exp_lat) begin
         failures++;
         $display("FAIL %s_latency: resp_o in cycle %0d expected %0d", name, lat, exp_lat);
      end
      checks++;
      if (line_o !== exp_line) begin
         failures++;
         $display("FAIL %s_line: line_o=%h expected %h", name, line_o, exp_line);
      end
   endtask

   // Write-back of LINE_W; returns at the negedge of the resp_o cycle
   task automatic run_write(input string name, input logic [31:0] a);
      logic [63:0] b;
      @(posedge clk); #1;
      write_i = 1'b1; read_i = 1'b0; line_i = LINE_W; address_i = a; resp_i = 1'b0;
      @(posedge clk); #1;
      for (int i = 1; i <= 4; i++) begin
         resp_i = 1'b1;
         if (i == 2) begin line_i = '0; address_i = '0; end
         b = LINE_W[64*(i-1) +: 64];
         @(negedge clk);
         checks++;
         if (burst_o !== b || write_o !== 1'b1 || resp_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_beat%0d: burst_o=%h write_o=%b resp_o=%b expected %h 1 0", name, i - 1, burst_o, write_o, resp_o, b);
         end
         if (i == 1) begin
            checks++;
            if (address_o !== {a[31:5], 5'b0} || read_o !== 1'b0) begin
               failures++;
               $display("FAIL %s_addr: address_o=%h read_o=%b expected %h 0", name, address_o, read_o, {a[31:5], 5'b0});
            end
         end
         @(posedge clk); #1;
      end
      resp_i = 1'b0;
      @(negedge clk);
      checks++;
      if (write_o !== 1'b0 || resp_o !== 1'b1 || burst_o !== 64'h0 || address_o !== 32'h0) begin
         failures++;
         $display("FAIL %s_done: write_o=%b resp_o=%b burst_o=%h address_o=%h expected 0 1 0 0", name, write_o, resp_o, burst_o, address_o);
      end
   endtask

   task automatic test_fill();
      run_fill("fill", 32'h0000_1234, LINE_A, 32'hFFFF_FFFF, 4 + FILL_EXTRA);
   endtask

   task automatic test_idle_resp();
      @(posedge clk); #1;
      read_i = 1'b0; write_i = 1'b0; resp_i = 1'b1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({resp_o, read_o, write_o} !== 3'b000 || address_o !== 32'h0 || line_o !== LINE_A) begin
            failures++;
            $display("FAIL idle_resp%0d: resp/read/write=%b address_o=%h line_o=%h expected 000 0 %h", i, {resp_o, read_o, write_o}, address_o, line_o, LINE_A);
         end
         @(posedge clk); #1;
      end
      resp_i = 1'b0;
   endtask

   task automatic test_write();
      run_write("write", 32'h0000_ABCD);
      @(posedge clk); #1;
      write_i = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_o !== 1'b0 || write_o !== 1'b0) begin
         failures++;
         $display("FAIL write_single_pulse: resp_o=%b write_o=%b expected 0 0", resp_o, write_o);
      end
   endtask

   task automatic test_stall_fill();
      run_fill("stall", 32'h8000_00FF, LINE_B, 32'b1011001, 7 + FILL_EXTRA);
   endtask

   task automatic test_both();
      @(posedge clk); #1;
      read_i = 1'b1; write_i = 1'b1; line_i = LINE_W; address_i = 32'h0000_4000; resp_i = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (write_o !== 1'b1 || read_o !== 1'b0) begin
         failures++;
         $display("FAIL both_priority: write_o=%b read_o=%b expected 1 0", write_o, read_o);
      end
      @(posedge clk); #1;
      resp_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 resp_i = 1'b1;
      @(posedge clk); #1;
      resp_i = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_o !== 1'b1 || line_o !== LINE_B) begin
         failures++;
         $display("FAIL both_done: resp_o=%b line_o=%h expected 1 %h", resp_o, line_o, LINE_B);
      end
      @(posedge clk); #1;
      read_i = 1'b0; write_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      run_write("b2b_write", 32'h0000_0040);
      run_fill("b2b_fill", 32'h0000_0060, LINE_A, 32'hFFFF_FFFF, 4 + FILL_EXTRA);
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      read_i = 1'b1; write_i = 1'b0; address_i = 32'h0000_2000; resp_i = 1'b0;
      @(posedge clk); #1;
      resp_i = 1'b1; burst_i = 64'h1234_5678_9ABC_DEF0;
      @(posedge clk); #1;
      burst_i = 64'h0FED_CBA9_8765_4321;
      @(posedge clk); #1;
      resp_i = 1'b0; read_i = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({resp_o, read_o, write_o} !== 3'b000 || address_o !== 32'h0 || burst_o !== 64'h0) begin
         failures++;
         $display("FAIL reset_mid_ctrl: resp/read/write=%b address_o=%h burst_o=%h expected 000 0 0", {resp_o, read_o, write_o}, address_o, burst_o);
      end
      checks++;
      if (line_o !== 256'h0) begin
         failures++;
         $display("FAIL reset_mid_line: line_o=%h expected 0", line_o);
      end
      run_fill("after_reset", 32'h0000_2000, LINE_B, 32'hFFFF_FFFF, 4 + FILL_EXTRA);
      @(posedge clk); #1;
      read_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_idle_resp();
      test_write();
      test_stall_fill();
      test_both();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Bridges the cache datapath's 256-bit line port to the 64-bit burst interface of physical memory. A line fill is collected from four consecutive 64-bit beats and presented as one 256-bit line. A line write-back is split into four beats. The block sits directly downstream of the cache datapath/control: it consumes `ca_addr`/`ca_wdata` and produces `ca_rdata` plus a one-cycle completion pulse.

## Interface
- `S_BEATS`, 4, beats per line; fixed at 4, so line width = 64·S_BEATS = 256
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `line_i`  in  256  write-back line (from `ca_wdata`)
- `line_o`  out  256  assembled fill line (to `ca_rdata`)
- `address_i`  in  32  line address (from `ca_addr`); bits [4:0] are ignored
- `read_i`  in  1  fill request; level, held until `resp_o`
- `write_i`  in  1  write-back request; level, held until `resp_o`
- `resp_o`  out  1  one-cycle completion pulse
- `burst_i`  in  64  memory read beat
- `burst_o`  out  64  memory write beat
- `address_o`  out  32  memory address, 32-byte aligned
- `read_o`  out  1  memory read request
- `write_o`  out  1  memory write request
- `resp_i`  in  1  memory beat strobe; one beat is transferred per cycle in which it is high

## Operation
- States: IDLE, READ, WRITE, DONE. There is a 2-bit beat counter `cnt`.
- IDLE:
  - `write_i` → WRITE. Write has priority if both requests are high (both high is illegal, but defined).
  - else `read_i` → READ.
  - On leaving IDLE: latch `{address_i[31:5],5'b0}` into the address register, latch `line_i` into the line buffer, clear `cnt`.
- READ:
  - `read_o`=1.
  - On `resp_i`: `line_o[64·cnt +: 64] <= burst_i`, then `cnt++`.
  - On `resp_i` with `cnt`==3 → DONE.
- WRITE:
  - `write_o`=1 and `burst_o` = buffer[64·cnt +: 64].
  - On `resp_i`: `cnt++`.
  - On `resp_i` with `cnt`==3 → DONE.
- DONE: `resp_o`=1 for exactly one cycle, then → IDLE unconditionally.
- Beat order is little-endian: beat 0 = bits [63:0], beat 3 = bits [255:192].
- `address_o` shows the latched address whenever the state is READ or WRITE, and 0 otherwise.
- `line_o` holds its value from the last fill until the next fill overwrites it beat by beat.
- `resp_i` in IDLE or DONE is ignored.
- `burst_o` = 0 outside WRITE.
- Changes on `address_i` or `line_i` during a burst have no effect, because both are latched.
- `cnt` wraps 3→0 only on the transition to DONE.

## Timing
- Reset values: `resp_o`=0, `read_o`=0, `write_o`=0, `address_o`=0, `burst_o`=0, `line_o`=0, state=IDLE, `cnt`=0.
- Reset mid-burst aborts the transfer: `read_o`/`write_o` are low the cycle after `rst` is sampled, and a partial `line_o` is cleared.
- A request sampled at edge E0 gives `read_o`/`write_o` high from cycle 1.
- With the memory returning `resp_i` on cycles 1–4 back to back, `resp_o` is high in cycle 5. Minimum latency is 5 cycles request-to-`resp_o`.
- Gaps in `resp_i` stall `cnt`; the request stays asserted with no timeout.
- The caller must drop `read_i`/`write_i` in the cycle after `resp_o`. The IDLE cycle that follows DONE guarantees no spurious restart.
- Back-to-back write-back then fill: a new request is accepted at the earliest one cycle after `resp_o`.

## Configuration
- `CACHELINE_ADAPTER_BYPASS_EN` defined (read path only):
  - `resp_o` asserts combinationally in the cycle the 4th read beat has `resp_i`=1.
  - In that cycle, `line_o` = {`burst_i`, registered beats 2..0}.
  - READ then goes straight to IDLE, so fill latency is 4 cycles.
- Write path is unchanged.
- Undefined: registered behaviour exactly as above; the fill completes through DONE.

## Test plan
- Fill of address 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles:
  - `address_o`=0x0000_1220.
  - `line_o`=0x44..44_33..33_22..22_11..11.
  - `resp_o` in cycle 5 (cycle 4 with `CACHELINE_ADAPTER_BYPASS_EN`).
- Write-back of `line_i`=0xDDDD…_CCCC…_BBBB…_AAAA…:
  - `burst_o` presents 0xAAAA…, 0xBBBB…, 0xCCCC…, 0xDDDD… in order.
  - `write_o` drops after the 4th `resp_i`.
  - exactly one `resp_o` pulse.
- `resp_i` pattern 1,0,0,1,1,0,1 during a fill: the four beats land in the correct slots and `resp_o` follows the final beat.
- `read_i` and `write_i` both high in IDLE: `write_o`=1 and `read_o`=0.
- `rst` asserted after 2 beats of a fill:
  - next cycle all outputs are 0 and `line_o`=0.
  - a new fill after reset completes normally.
- `resp_i`=1 while idle: no state change, `resp_o` stays 0.
